// File: rtl/frodo_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frodo_io_sequencer
// Description : Control-only handshake scheduler between the host port and
//               the FrodoKEM-1344 core. Walks a fixed per-command table of
//               IN/OUT word segments and gates the valid/ready wires so only
//               the active direction can transfer. Data bypasses this block.
// Revision    : 1.0 - initial release
// ============================================================================
module frodo_io_sequencer #(
  parameter int CMD_W    = 3,
  parameter int LEN_MAT  = 2688,
  parameter int LEN_C2   = 16,
  parameter int LEN_SALT = 8,
  parameter int LEN_KEY  = 4,
  parameter int LEN_SEED = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_isReady,
  output logic             cmd_canReceive,
  input  logic             ext_in_isReady,
  output logic             ext_in_canReceive,
  output logic             ext_out_isReady,
  input  logic             ext_out_canReceive,
  output logic             dp_in_isReady,
  input  logic             dp_in_canReceive,
  input  logic             dp_out_isReady,
  output logic             dp_out_canReceive,
  output logic [CMD_W-1:0] op,
  output logic [3:0]       seg_idx,
  output logic [11:0]      word_idx,
  output logic             op_done,
  output logic             err_badCmd
);

  // Command codes
  localparam logic [CMD_W-1:0] C_OP_SETUP  = CMD_W'(1);
  localparam logic [CMD_W-1:0] C_OP_KEYGEN = CMD_W'(2);
  localparam logic [CMD_W-1:0] C_OP_ENCAPS = CMD_W'(3);
  localparam logic [CMD_W-1:0] C_OP_DECAPS = CMD_W'(4);

  // Segment lengths at word-counter width
  localparam logic [11:0] C_L_MAT  = 12'(LEN_MAT);
  localparam logic [11:0] C_L_C2   = 12'(LEN_C2);
  localparam logic [11:0] C_L_SALT = 12'(LEN_SALT);
  localparam logic [11:0] C_L_KEY  = 12'(LEN_KEY);
  localparam logic [11:0] C_L_SEED = 12'(LEN_SEED);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic        w_seg_out;     // active segment streams core -> host
  logic [11:0] w_seg_len;     // words in active segment
  logic        w_seg_last;    // active segment is the final one of the command
  logic        w_cmd_valid;
  logic        w_xfer;
  logic        w_word_last;
  logic        w_op_last;

  // Segment table: direction, length and last-flag for (op, seg_idx)
  always_comb begin
    w_seg_out  = 1'b0;
    w_seg_len  = C_L_KEY;
    w_seg_last = 1'b0;
    case (op)
      C_OP_SETUP: begin
        case (seg_idx)
          4'd0:    w_seg_len = C_L_SALT;
          4'd1:    w_seg_len = C_L_KEY;
          4'd2:    w_seg_len = C_L_SALT;
          default: begin w_seg_len = C_L_SEED; w_seg_last = 1'b1; end
        endcase
      end
      C_OP_KEYGEN: begin
        w_seg_out = 1'b1;
        case (seg_idx)
          4'd0:    w_seg_len = C_L_KEY;
          4'd1:    w_seg_len = C_L_MAT;
          4'd2:    w_seg_len = C_L_SEED;
          4'd3:    w_seg_len = C_L_MAT;
          default: begin w_seg_len = C_L_KEY; w_seg_last = 1'b1; end
        endcase
      end
      C_OP_ENCAPS: begin
        case (seg_idx)
          4'd0:    w_seg_len = C_L_SEED;
          4'd1:    w_seg_len = C_L_MAT;
          4'd2:    begin w_seg_out = 1'b1; w_seg_len = C_L_MAT;  end
          4'd3:    begin w_seg_out = 1'b1; w_seg_len = C_L_C2;   end
          4'd4:    begin w_seg_out = 1'b1; w_seg_len = C_L_SALT; end
          default: begin w_seg_out = 1'b1; w_seg_len = C_L_KEY; w_seg_last = 1'b1; end
        endcase
      end
      C_OP_DECAPS: begin
        case (seg_idx)
          4'd0:    w_seg_len = C_L_MAT;
          4'd1:    w_seg_len = C_L_MAT;
          4'd2:    w_seg_len = C_L_C2;
          4'd3:    w_seg_len = C_L_SALT;
          4'd4:    w_seg_len = C_L_KEY;
          4'd5:    w_seg_len = C_L_MAT;
          4'd6:    w_seg_len = C_L_SEED;
          4'd7:    w_seg_len = C_L_KEY;
          default: begin w_seg_out = 1'b1; w_seg_len = C_L_KEY; w_seg_last = 1'b1; end
        endcase
      end
      default: begin
        w_seg_out  = 1'b0;
        w_seg_len  = C_L_KEY;
        w_seg_last = 1'b0;
      end
    endcase
  end

  assign w_cmd_valid = (cmd >= C_OP_SETUP) && (cmd <= C_OP_DECAPS);

  // A transfer needs both sides of the active direction only
  assign w_xfer      = (r_state == ST_RUN) &&
                       (w_seg_out ? (dp_out_isReady && ext_out_canReceive)
                                  : (ext_in_isReady && dp_in_canReceive));
  assign w_word_last = (word_idx == (w_seg_len - 12'd1));
  assign w_op_last   = w_xfer && w_word_last && w_seg_last;

  // State register; reset drops straight back to RESET
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and handshake gating (zero-latency pass-through in RUN)
  always_comb begin
    w_state_nx         = r_state;
    cmd_canReceive     = 1'b0;
    ext_in_canReceive  = 1'b0;
    dp_in_isReady      = 1'b0;
    ext_out_isReady    = 1'b0;
    dp_out_canReceive  = 1'b0;
    op_done            = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        cmd_canReceive = 1'b1;
        if (cmd_isReady && w_cmd_valid) begin
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_seg_out) begin
          ext_out_isReady   = dp_out_isReady;
          dp_out_canReceive = ext_out_canReceive;
        end else begin
          ext_in_canReceive = dp_in_canReceive;
          dp_in_isReady     = ext_in_isReady;
        end
        op_done = w_op_last;
        if (w_op_last) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Command latch, segment/word counters and bad-command pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op         <= '0;
      seg_idx    <= 4'd0;
      word_idx   <= 12'd0;
      err_badCmd <= 1'b0;
    end else begin
      err_badCmd <= (r_state == ST_IDLE) && cmd_isReady && !w_cmd_valid;
      if (r_state == ST_IDLE) begin
        if (cmd_isReady && w_cmd_valid) begin
          op       <= cmd;
          seg_idx  <= 4'd0;
          word_idx <= 12'd0;
        end
      end else if (w_xfer) begin
        if (w_word_last) begin
          word_idx <= 12'd0;
          if (w_seg_last) begin
            seg_idx <= 4'd0;
            op      <= '0;
          end else begin
            seg_idx <= seg_idx + 4'd1;
          end
        end else begin
          word_idx <= word_idx + 12'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frodo_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frodo_io_sequencer
// Description : Randomized self-checking bench for frodo_io_sequencer against
//               a word-position reference model of the command tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frodo_io_sequencer;

  localparam int CMD_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CMD_W-1:0] cmd = '0;
  logic             cmd_isReady = 1'b0;
  logic             ext_in_isReady = 1'b0;
  logic             ext_out_canReceive = 1'b0;
  logic             dp_in_canReceive = 1'b0;
  logic             dp_out_isReady = 1'b0;
  logic             cmd_canReceive;
  logic             ext_in_canReceive;
  logic             ext_out_isReady;
  logic             dp_in_isReady;
  logic             dp_out_canReceive;
  logic [CMD_W-1:0] op;
  logic [3:0]       seg_idx;
  logic [11:0]      word_idx;
  logic             op_done;
  logic             err_badCmd;

  always #5 clk = ~clk;

  frodo_io_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .cmd                (cmd),
    .cmd_isReady        (cmd_isReady),
    .cmd_canReceive     (cmd_canReceive),
    .ext_in_isReady     (ext_in_isReady),
    .ext_in_canReceive  (ext_in_canReceive),
    .ext_out_isReady    (ext_out_isReady),
    .ext_out_canReceive (ext_out_canReceive),
    .dp_in_isReady      (dp_in_isReady),
    .dp_in_canReceive   (dp_in_canReceive),
    .dp_out_isReady     (dp_out_isReady),
    .dp_out_canReceive  (dp_out_canReceive),
    .op                 (op),
    .seg_idx            (seg_idx),
    .word_idx           (word_idx),
    .op_done            (op_done),
    .err_badCmd         (err_badCmd)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: command = list of (dir, len) ----------
  localparam int L_MAT = 2688, L_C2 = 16, L_SALT = 8, L_KEY = 4, L_SEED = 2;
  int m_dir[$];
  int m_len[$];
  int m_total;
  bit m_idle = 1'b0;
  bit m_run  = 1'b0;
  bit m_err  = 1'b0;
  int m_op   = 0;
  int m_pos  = 0;          // words already moved in the current command
  bit m_xf;

  // DUT-observed statistics
  int in_x, out_x, bad_in_cr, done_cnt, err_cnt, seg_at_done, xfer_at_done;

  function automatic bit valid_code(input int c);
    return (c >= 1) && (c <= 4);
  endfunction

  task automatic add(input int d, input int l);
    m_dir.push_back(d);
    m_len.push_back(l);
    m_total += l;
  endtask

  task automatic load_table(input int c);
    m_dir.delete();
    m_len.delete();
    m_total = 0;
    case (c)
      1: begin add(0, L_SALT); add(0, L_KEY); add(0, L_SALT); add(0, L_SEED); end
      2: begin add(1, L_KEY); add(1, L_MAT); add(1, L_SEED); add(1, L_MAT); add(1, L_KEY); end
      3: begin add(0, L_SEED); add(0, L_MAT); add(1, L_MAT); add(1, L_C2); add(1, L_SALT); add(1, L_KEY); end
      default: begin
        add(0, L_MAT); add(0, L_MAT); add(0, L_C2); add(0, L_SALT);
        add(0, L_KEY); add(0, L_MAT); add(0, L_SEED); add(0, L_KEY); add(1, L_KEY);
      end
    endcase
  endtask

  function automatic void locate(input int pos, output int seg, output int word);
    int base = 0;
    seg  = 0;
    word = pos;
    for (int i = 0; i < m_len.size(); i++) begin
      if (pos < base + m_len[i]) begin
        seg  = i;
        word = pos - base;
        return;
      end
      base += m_len[i];
    end
  endfunction

  task automatic model_reset();
    m_idle = 1'b0;
    m_run  = 1'b0;
    m_err  = 1'b0;
    m_op   = 0;
    m_pos  = 0;
  endtask

  task automatic clear_stats();
    in_x = 0; out_x = 0; bad_in_cr = 0; done_cnt = 0; err_cnt = 0;
    seg_at_done = -1; xfer_at_done = -1;
  endtask

  // Compare every output against the model for the current inputs
  task automatic check_now();
    int s, w;
    bit in_act, out_act, last;
    logic [6:0]  exp_hs, got_hs;
    logic [18:0] exp_ix, got_ix;
    s = 0; w = 0; in_act = 1'b0; out_act = 1'b0;
    if (m_run) begin
      locate(m_pos, s, w);
      in_act  = (m_dir[s] == 0);
      out_act = (m_dir[s] == 1);
    end
    m_xf = (in_act && ext_in_isReady && dp_in_canReceive) ||
           (out_act && dp_out_isReady && ext_out_canReceive);
    last = m_xf && (m_pos == m_total - 1);
    exp_hs = {m_idle, in_act & dp_in_canReceive, in_act & ext_in_isReady,
              out_act & dp_out_isReady, out_act & ext_out_canReceive, last, m_err};
    got_hs = {cmd_canReceive, ext_in_canReceive, dp_in_isReady,
              ext_out_isReady, dp_out_canReceive, op_done, err_badCmd};
    check_val("handshake", 32'(got_hs), 32'(exp_hs));
    exp_ix = {m_op[2:0], s[3:0], w[11:0]};
    got_ix = {op, seg_idx, word_idx};
    check_val("op_seg_word", 32'(got_ix), 32'(exp_ix));
    if (ext_in_isReady && ext_in_canReceive) in_x++;
    if (ext_out_isReady && ext_out_canReceive) out_x++;
    if (out_act && ext_in_isReady && ext_in_canReceive) bad_in_cr++;
    if (ext_in_canReceive && !in_act) bad_in_cr++;
    if (op_done) begin
      done_cnt++;
      seg_at_done  = int'(seg_idx);
      xfer_at_done = in_x + out_x;
    end
    if (err_badCmd) err_cnt++;
  endtask

  task automatic update();
    if (!rst) begin
      model_reset();
    end else if (!m_idle && !m_run) begin
      m_idle = 1'b1;
      m_err  = 1'b0;
    end else if (m_idle) begin
      m_err = cmd_isReady && !valid_code(int'(cmd));
      if (cmd_isReady && valid_code(int'(cmd))) begin
        load_table(int'(cmd));
        m_op   = int'(cmd);
        m_pos  = 0;
        m_idle = 1'b0;
        m_run  = 1'b1;
      end
    end else begin
      m_err = 1'b0;
      if (m_xf) begin
        m_pos++;
        if (m_pos == m_total) begin
          m_run  = 1'b0;
          m_idle = 1'b1;
          m_op   = 0;
        end
      end
    end
  endtask

  // Inputs are driven at the falling edge; step checks, clocks, updates model
  task automatic step();
    #1;
    check_now();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic drive(input int p_ei, input int p_di, input int p_do, input int p_eo);
    ext_in_isReady     = (int'($urandom_range(99)) < p_ei);
    dp_in_canReceive   = (int'($urandom_range(99)) < p_di);
    dp_out_isReady     = (int'($urandom_range(99)) < p_do);
    ext_out_canReceive = (int'($urandom_range(99)) < p_eo);
  endtask

  task automatic issue(input int c);
    cmd = CMD_W'(c);
    cmd_isReady = 1'b1;
    step();
    cmd_isReady = 1'b0;
    cmd = CMD_W'($urandom_range(7));
  endtask

  task automatic run_to_idle(input string tag, input int p_ei, input int p_di,
                             input int p_do, input int p_eo, input bit toggle_eo);
    int cyc = 0;
    while (m_run && cyc < 30000 && n_mis < 50) begin
      drive(p_ei, p_di, p_do, p_eo);
      if (toggle_eo) ext_out_canReceive = cyc[0];
      step();
      cyc++;
    end
    check_val(tag, 32'(m_run), 32'(0));
  endtask

  function automatic int t1_seg_exp(input int k);
    if (k < 8)  return 0;
    if (k < 12) return 1;
    if (k < 20) return 2;
    return 3;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit stalled;
    logic [25:0] all_outs;
    clear_stats();
    @(negedge clk);
    // Reset state
    step();
    step();
    rst = 1'b1;
    step();
    check_val("idle_after_reset", 32'(cmd_canReceive), 32'(1));

    // 1: setupTest at full rate
    clear_stats();
    issue(1);
    cyc = 0;
    while (m_run && cyc < 100 && n_mis < 50) begin
      drive(100, 100, 100, 100);
      step();
      cyc++;
      if (in_x < 22) check_val("t1_seg", 32'(seg_idx), 32'(t1_seg_exp(in_x)));
    end
    #1;
    check_val("t1_cycles", 32'(cyc), 32'(22));
    check_val("t1_done_at", 32'(xfer_at_done), 32'(22));
    check_val("t1_ready_next", 32'(cmd_canReceive), 32'(1));
    check_val("t1_in_count", 32'(in_x), 32'(22));

    // 2: keygen, host out-ready toggling
    clear_stats();
    issue(2);
    run_to_idle("t2_finish", 60, 60, 80, 0, 1'b1);
    check_val("t2_out_count", 32'(out_x), 32'(5386));
    check_val("t2_in_count", 32'(in_x), 32'(0));
    check_val("t2_in_cr_seen", 32'(bad_in_cr), 32'(0));
    check_val("t2_seg_at_done", 32'(seg_at_done), 32'(4));
    check_val("t2_done_cnt", 32'(done_cnt), 32'(1));

    // 3: encaps with random offers in both directions
    clear_stats();
    issue(3);
    run_to_idle("t3_finish", 75, 75, 75, 75, 1'b0);
    check_val("t3_in_count", 32'(in_x), 32'(2690));
    check_val("t3_out_count", 32'(out_x), 32'(2716));
    check_val("t3_in_cr_in_out_seg", 32'(bad_in_cr), 32'(0));

    // 4: decaps with a core stall at word 2687
    clear_stats();
    issue(4);
    cyc = 0;
    stalled = 1'b0;
    while (m_run && cyc < 30000 && n_mis < 50) begin
      drive(90, 90, 90, 90);
      if (!stalled && m_pos == 2687) begin
        stalled = 1'b1;
        for (int i = 0; i < 10; i++) begin
          ext_in_isReady   = 1'b1;
          dp_in_canReceive = 1'b0;
          step();
          check_val("t4_stall_cr", 32'(ext_in_canReceive), 32'(0));
          check_val("t4_stall_word", 32'(word_idx), 32'(2687));
        end
      end else begin
        step();
      end
      cyc++;
    end
    check_val("t4_finish", 32'(m_run), 32'(0));
    check_val("t4_in_count", 32'(in_x), 32'(8098));
    check_val("t4_out_count", 32'(out_x), 32'(4));

    // 5: invalid codes in IDLE, then a command offered during RUN
    clear_stats();
    issue(0);
    step();
    issue(7);
    step();
    step();
    check_val("t5_err_pulses", 32'(err_cnt), 32'(2));
    issue(1);
    for (int i = 0; i < 4; i++) begin
      drive(50, 50, 50, 50);
      cmd = CMD_W'(2);
      cmd_isReady = 1'b1;
      step();
    end
    cmd_isReady = 1'b0;
    #1;
    check_val("t5_op_held", 32'(op), 32'(1));
    check_val("t5_no_extra_err", 32'(err_cnt), 32'(2));
    run_to_idle("t5_finish", 80, 80, 80, 80, 1'b0);

    // 6: asynchronous reset in the middle of encaps
    clear_stats();
    issue(3);
    cyc = 0;
    while (m_run && (in_x + out_x) < 1000 && cyc < 5000 && n_mis < 50) begin
      drive(80, 80, 80, 80);
      step();
      cyc++;
    end
    ext_in_isReady   = 1'b1;
    dp_in_canReceive = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    all_outs = {cmd_canReceive, ext_in_canReceive, ext_out_isReady, dp_in_isReady,
                dp_out_canReceive, op, seg_idx, word_idx, op_done, err_badCmd};
    check_val("t6_async_zero", 32'(all_outs), 32'(0));
    @(negedge clk);
    step();
    step();
    check_val("t6_no_done", 32'(done_cnt), 32'(0));
    rst = 1'b1;
    step();
    clear_stats();
    issue(2);
    #1;
    check_val("t6_restart", 32'({op, seg_idx, word_idx}), 32'({3'd2, 4'd0, 12'd0}));
    run_to_idle("t6_finish", 100, 100, 100, 100, 1'b0);
    check_val("t6_out_count", 32'(out_x), 32'(5386));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
